// File: rtl/anim_pkg.sv
// Shared state encodings and widths for the character animation sequencer.
package anim_pkg;
  localparam int STATE_OUT_W = 8;

  typedef enum logic [2:0] {
    ST_STAND  = 3'd0,
    ST_ATTACK = 3'd1,
    ST_MOVE_L = 3'd2,
    ST_MOVE_R = 3'd3,
    ST_HURT   = 3'd4,
    ST_DEFEND = 3'd5
  } anim_state_t;
endpackage

// File: rtl/anim_tick_sync.sv
// Brings the asynchronous frame_clk level into the Clk domain and emits a
// registered one-cycle tick three Clk edges after each rising edge.
module anim_tick_sync (
  input  logic Clk,
  input  logic Reset_n,
  input  logic frame_clk,
  output logic tick
);
  // [1:0] form the synchroniser, [2] holds the previous synced level
  logic [2:0] sync_q;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sync_q <= '0;
      tick   <= 1'b0;
    end else begin
      sync_q <= {sync_q[1:0], frame_clk};
      tick   <= sync_q[1] & ~sync_q[2];
    end
  end
endmodule

// File: rtl/character_anim_fsm.sv
// Per-character animation sequencer: picks stand/move/attack/hurt/defend on
// each frame tick and steps the sprite frame index with per-state hold delays.
module character_anim_fsm
  import anim_pkg::*;
#(
  parameter int FRAME_W          = 8,
  parameter int DELAY_W          = 8,
  parameter int DELAY_STAND      = 10,
  parameter int FRAMES_STAND     = 7,
  parameter int DELAY_MOVE       = 10,
  parameter int FRAMES_MOVE_R    = 3,
  parameter int FRAMES_MOVE_L    = 4,
  parameter int DELAY_ATTACK     = 3,
  parameter int FRAMES_ATTACK    = 8,
  parameter int ATTACK_HIT_FRAME = 4,
  parameter int DELAY_HURT       = 3,
  parameter int FRAMES_HURT      = 3,
  parameter int DELAY_DEFEND     = 5,
  parameter int FRAMES_DEFEND    = 2
) (
  input  logic                   Clk,
  input  logic                   Reset_n,
  input  logic                   frame_clk,
  input  logic                   attack_req,
  input  logic                   move_r_req,
  input  logic                   move_l_req,
  input  logic                   defend_req,
  input  logic                   hurt_req,
  output logic [STATE_OUT_W-1:0] state_out,
  output logic [FRAME_W-1:0]     frame_num,
  output logic                   move_r,
  output logic                   move_l,
  output logic                   attack_hit,
  output logic                   busy
);
  anim_state_t        state, nxt_state, tgt_state;
  logic [FRAME_W-1:0] frame, nxt_frame, frm_lim;
  logic [DELAY_W-1:0] delay, nxt_delay, dly_lim;
  logic               hurt_pending, tick, hit_nxt, restart;

  anim_tick_sync u_tick_sync (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .frame_clk (frame_clk),
    .tick      (tick)
  );

  always_comb begin
    dly_lim = DELAY_W'(DELAY_STAND);
    frm_lim = FRAME_W'(FRAMES_STAND);
    case (state)
      ST_ATTACK: begin dly_lim = DELAY_W'(DELAY_ATTACK); frm_lim = FRAME_W'(FRAMES_ATTACK); end
      ST_MOVE_L: begin dly_lim = DELAY_W'(DELAY_MOVE);   frm_lim = FRAME_W'(FRAMES_MOVE_L); end
      ST_MOVE_R: begin dly_lim = DELAY_W'(DELAY_MOVE);   frm_lim = FRAME_W'(FRAMES_MOVE_R); end
      ST_HURT:   begin dly_lim = DELAY_W'(DELAY_HURT);   frm_lim = FRAME_W'(FRAMES_HURT);   end
      ST_DEFEND: begin dly_lim = DELAY_W'(DELAY_DEFEND); frm_lim = FRAME_W'(FRAMES_DEFEND); end
      default:   ;
    endcase
  end

  always_comb begin
    restart   = 1'b0;
    tgt_state = ST_STAND;
    if (hurt_pending) begin
      tgt_state = ST_HURT;
      restart   = 1'b1;
    end else if (state == ST_ATTACK || state == ST_HURT) tgt_state = state;
    else if (defend_req) tgt_state = ST_DEFEND;
    else if (attack_req) tgt_state = ST_ATTACK;
    else if (move_r_req) tgt_state = ST_MOVE_R;
    else if (move_l_req) tgt_state = ST_MOVE_L;
  end

  always_comb begin
    nxt_state = state;
    nxt_frame = frame;
    nxt_delay = delay;
    hit_nxt   = 1'b0;
    if (restart || tgt_state != state) begin
      nxt_state = tgt_state;
      nxt_frame = '0;
      nxt_delay = '0;
    end else if (delay >= dly_lim) begin
      nxt_delay = '0;
      if (frame >= frm_lim) begin
        case (state)
          ST_ATTACK, ST_HURT: begin nxt_state = ST_STAND; nxt_frame = '0; end
          ST_DEFEND:          nxt_frame = frm_lim;
          default:            nxt_frame = '0;
        endcase
      end else begin
        nxt_frame = frame + 1'b1;
        hit_nxt   = (state == ST_ATTACK) && (frame == FRAME_W'(ATTACK_HIT_FRAME - 1));
      end
    end else begin
      nxt_delay = delay + 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state        <= ST_STAND;
      frame        <= '0;
      delay        <= '0;
      hurt_pending <= 1'b0;
      move_r       <= 1'b0;
      move_l       <= 1'b0;
      attack_hit   <= 1'b0;
      busy         <= 1'b0;
    end else begin
      // a hit arriving on the consuming tick must not be lost
      if (hurt_req)  hurt_pending <= 1'b1;
      else if (tick) hurt_pending <= 1'b0;
      move_r     <= 1'b0;
      move_l     <= 1'b0;
      attack_hit <= 1'b0;
      if (tick) begin
        state      <= nxt_state;
        frame      <= nxt_frame;
        delay      <= nxt_delay;
        move_r     <= (nxt_state == ST_MOVE_R);
        move_l     <= (nxt_state == ST_MOVE_L);
        attack_hit <= hit_nxt;
        busy       <= (nxt_state == ST_ATTACK) || (nxt_state == ST_HURT);
      end
    end
  end

  assign state_out = STATE_OUT_W'(state);
  assign frame_num = frame;
endmodule
